// File: rtl/spi_pkg.sv
// Shared widths, instruction field layout and FSM states for the SPI request arbiter.
// Instruction packing (MSB..LSB): {SS[1:0], WDATA, ADDR, SIZE[1:0], WR_EN}.
package spi_pkg;

  localparam int AWIDTH    = 8;
  localparam int DWIDTH    = 8;
  localparam int IW        = DWIDTH + AWIDTH + 5;

  localparam int WR_EN_POS = 0;
  localparam int SIZE_LSB  = 1;
  localparam int ADDR_LSB  = 3;
  localparam int WDATA_LSB = ADDR_LSB + AWIDTH;
  localparam int SS_LSB    = WDATA_LSB + DWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_e;

  function automatic logic [AWIDTH-1:0] cmd_addr(input logic [IW-1:0] cmd);
    return cmd[ADDR_LSB +: AWIDTH];
  endfunction

  function automatic logic cmd_is_write(input logic [IW-1:0] cmd);
    return cmd[WR_EN_POS];
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr.sv
// Round-robin picker: the first active request found searching upward
// from the slot just after the previous owner, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int OW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic [OW-1:0]   winner,
  output logic            any
);

  logic [OW:0]       start;
  logic [2*NREQ-1:0] doubled;
  logic [NREQ-1:0]   rotated;
  int                pick;
  int                sum;

  // Rotate the request vector so bit 0 is the highest-priority slot, then
  // take the lowest set bit and map it back to an absolute index.
  always_comb begin
    start   = (OW+1)'(last_owner) + (OW+1)'(1);
    doubled = {req, req};
    rotated = NREQ'(doubled >> start);
    pick    = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rotated[j]) pick = j;
    end
    sum = int'(start) + pick;
    if (sum >= NREQ) sum = sum - NREQ;
    winner = OW'(sum);
    any    = |req;
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master among NREQ requesters: round-robin grant, one
// instruction in flight, read responses routed back with timeout/address check.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][IW-1:0]  req_cmd,
  output logic [NREQ-1:0]          req_ready,
  output logic                     master_en,
  output logic [IW-1:0]            driver_data,
  input  logic                     driver_read,
  input  logic                     spi_rd_valid,
  input  logic [AWIDTH-1:0]        spi_slv_addr,
  input  logic [DWIDTH-1:0]        spi_slv_data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_e      state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   last_owner;
  logic [CW-1:0]   tmo_cnt;
  logic [OW-1:0]   arb_winner;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_owner (last_owner),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  assign busy = (state != ST_IDLE);

  // Pulse outputs (req_ready, rsp_*) default low every cycle so each is a
  // single-cycle strobe; driver_data is left holding the last instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_owner  <= OW'(NREQ - 1);
      tmo_cnt     <= '0;
      master_en   <= 1'b0;
      driver_data <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            driver_data           <= req_cmd[arb_winner];
            owner                 <= arb_winner;
            req_ready[arb_winner] <= 1'b1;
            master_en             <= 1'b1;
            state                 <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (driver_read) begin
            master_en  <= 1'b0;
            last_owner <= owner;
            if (cmd_is_write(driver_data)) begin
              state <= ST_IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= ST_WAIT_RSP;
            end
          end
        end
        ST_WAIT_RSP: begin
          // Real data wins over a timeout landing on the same edge.
          if (spi_rd_valid) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data         <= spi_slv_data;
            rsp_err          <= (spi_slv_addr != cmd_addr(driver_data));
            state            <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= 1'b1;
            tmo_cnt          <= '0;
            state            <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: begin
          master_en <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed vectors and corner
// sequences, then randomized transactions against a transaction-level model.
module tb_spi_req_arbiter;
  import spi_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 20;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][IW-1:0] req_cmd;
  logic [NREQ-1:0]         req_ready;
  logic                    master_en;
  logic [IW-1:0]           driver_data;
  logic                    driver_read;
  logic                    spi_rd_valid;
  logic [AWIDTH-1:0]       spi_slv_addr;
  logic [DWIDTH-1:0]       spi_slv_data;
  logic [NREQ-1:0]         rsp_valid;
  logic [DWIDTH-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  spi_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .master_en    (master_en),
    .driver_data  (driver_data),
    .driver_read  (driver_read),
    .spi_rd_valid (spi_rd_valid),
    .spi_slv_addr (spi_slv_addr),
    .spi_slv_data (spi_slv_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[9];

  // Transaction-level model state
  int              model_last;
  int              exp_win;
  logic [3:0]      r_mask;
  logic [IW-1:0]   r_cmd;
  logic [DWIDTH-1:0] r_data;
  logic [AWIDTH-1:0] r_addr;
  int              r_lat, r_k, r_at;
  logic            r_match, early;
  logic [DWIDTH-1:0] exp_data;
  logic            exp_err;
  int              grants[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk_cmd(input logic [7:0] wdata, input logic [7:0] addr,
                                           input logic wr);
    return {2'b01, wdata, addr, 2'b00, wr};
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int i = 1; i <= NREQ; i++) begin
      if (mask[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_stimulus(input logic [3:0] mask);
    req_valid = mask;
    tick();
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; driver_read = 1'b0; spi_rd_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_last = NREQ - 1;
  endtask

  // Grant requester idx with cmd and let the master consume it right away.
  task automatic grant_and_consume(input int idx, input logic [IW-1:0] cmd);
    req_cmd[idx] = cmd;
    apply_stimulus(4'(1) << idx);
    check_output("grant_ready", req_ready, 4'(1) << idx);
    check_output("grant_data", driver_data, cmd);
    driver_read = 1'b1;
    tick();
    driver_read = 1'b0;
    check_output("consumed_master_en", master_en, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_cmd = '0; driver_read = 1'b0;
    spi_rd_valid = 1'b0; spi_slv_addr = '0; spi_slv_data = '0;
    vecs[0] = '{4'b0101, 4'b0001};
    vecs[1] = '{4'b0101, 4'b0100};
    vecs[2] = '{4'b0101, 4'b0001};
    vecs[3] = '{4'b1000, 4'b1000};
    vecs[4] = '{4'b1010, 4'b0010};
    vecs[5] = '{4'b0010, 4'b0010};
    vecs[6] = '{4'b1111, 4'b0100};
    vecs[7] = '{4'b0000, 4'b0000};
    vecs[8] = '{4'b0011, 4'b0001};

    tick(); tick();
    check_output("rst_outputs",
                 {master_en, driver_data, req_ready, rsp_valid, rsp_data, rsp_err, busy}, 0);
    rst = 1'b0;
    model_last = NREQ - 1;

    // Single write from requester 0
    req_cmd[0] = mk_cmd(8'h11, 8'h03, 1'b1);
    apply_stimulus(4'b0001);
    check_output("wr_ready", req_ready, 4'b0001);
    check_output("wr_master_en", master_en, 1);
    check_output("wr_busy", busy, 1);
    tick();
    check_output("wr_ready_pulse", req_ready, 0);
    check_output("wr_hold_en", master_en, 1);
    check_output("wr_hold_data", driver_data, mk_cmd(8'h11, 8'h03, 1'b1));
    driver_read = 1'b1;
    tick();
    driver_read = 1'b0;
    check_output("wr_done_en", master_en, 0);
    check_output("wr_done_busy", busy, 0);
    check_output("wr_no_rsp", rsp_valid, 0);

    // Read from requester 2, data back 10 cycles after driver_read
    do_reset();
    grant_and_consume(2, mk_cmd(8'h00, 8'h05, 1'b0));
    early = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      early |= (rsp_valid != 0);
    end
    check_output("rd_no_early_rsp", early, 0);
    spi_rd_valid = 1'b1; spi_slv_addr = 8'h05; spi_slv_data = 8'hA5;
    tick();
    spi_rd_valid = 1'b0;
    check_output("rd_rsp_valid", rsp_valid, 4'b0100);
    check_output("rd_rsp_data", rsp_data, 8'hA5);
    check_output("rd_rsp_err", rsp_err, 0);
    tick();
    check_output("rd_rsp_pulse", rsp_valid, 0);
    check_output("rd_idle", busy, 0);

    // Fairness: all requesters held, writes
    do_reset();
    for (int i = 0; i < NREQ; i++) req_cmd[i] = mk_cmd(8'(i), 8'(i), 1'b1);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int cyc;
      cyc = 0;
      grants[g] = -1;
      while (grants[g] < 0 && cyc < 6) begin
        tick();
        cyc++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[g] = i;
      end
      check_output($sformatf("fair_grant%0d", g), 64'(grants[g]), 64'(g % NREQ));
      driver_read = 1'b1;
      tick();
      driver_read = 1'b0;
    end
    req_valid = '0;
    tick();

    // Round-robin table from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) req_cmd[i] = mk_cmd(8'hF0, 8'(i), 1'b1);
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].mask);
      check_output($sformatf("tbl%0d_ready", v), req_ready, vecs[v].exp_ready);
      check_output($sformatf("tbl%0d_en", v), master_en, vecs[v].exp_ready != 0);
      if (vecs[v].exp_ready != 0) begin
        driver_read = 1'b1;
        tick();
        driver_read = 1'b0;
      end
    end

    // Timeout with no data, then data landing on the timeout edge
    do_reset();
    grant_and_consume(3, mk_cmd(8'h00, 8'h07, 1'b0));
    early = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      early |= (rsp_valid != 0);
    end
    check_output("tmo_no_early_rsp", early, 0);
    tick();
    check_output("tmo_rsp_valid", rsp_valid, 4'b1000);
    check_output("tmo_rsp_err", rsp_err, 1);
    check_output("tmo_rsp_data", rsp_data, 0);
    grant_and_consume(3, mk_cmd(8'h00, 8'h07, 1'b0));
    for (int i = 1; i < TMO; i++) tick();
    spi_rd_valid = 1'b1; spi_slv_addr = 8'h07; spi_slv_data = 8'h3C;
    tick();
    spi_rd_valid = 1'b0;
    check_output("tie_rsp_valid", rsp_valid, 4'b1000);
    check_output("tie_rsp_err", rsp_err, 0);
    check_output("tie_rsp_data", rsp_data, 8'h3C);

    // Address mismatch
    grant_and_consume(1, mk_cmd(8'h00, 8'h05, 1'b0));
    tick();
    spi_rd_valid = 1'b1; spi_slv_addr = 8'h06; spi_slv_data = 8'h5A;
    tick();
    spi_rd_valid = 1'b0;
    check_output("mis_rsp_valid", rsp_valid, 4'b0010);
    check_output("mis_rsp_err", rsp_err, 1);

    // Reset while waiting for read data
    grant_and_consume(0, mk_cmd(8'h00, 8'h09, 1'b0));
    tick(); tick();
    check_output("rstw_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_output("rstw_outputs",
                 {master_en, driver_data, req_ready, rsp_valid, rsp_data, rsp_err, busy}, 0);
    tick();
    rst = 1'b0;
    spi_rd_valid = 1'b1; spi_slv_addr = 8'h09; spi_slv_data = 8'h77;
    tick();
    spi_rd_valid = 1'b0;
    check_output("rstw_no_rsp", rsp_valid, 0);
    tick();
    check_output("rstw_still_idle", {busy, rsp_valid}, 0);

    // Randomized transactions against the model
    do_reset();
    for (int t = 0; t < 60; t++) begin
      r_mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) req_cmd[i] = IW'($urandom);
      exp_win = rr_pick(model_last, r_mask);
      r_cmd = req_cmd[exp_win];
      driver_read  = 1'($urandom_range(0, 1));
      spi_rd_valid = 1'($urandom_range(0, 1));
      spi_slv_addr = 8'($urandom);
      apply_stimulus(r_mask);
      driver_read = 1'b0; spi_rd_valid = 1'b0;
      check_output("rnd_ready", req_ready, 4'(1) << exp_win);
      check_output("rnd_data", driver_data, r_cmd);
      check_output("rnd_no_rsp", rsp_valid, 0);
      r_lat = $urandom_range(0, 2);
      for (int i = 0; i < r_lat; i++) begin
        tick();
        check_output("rnd_hold", {master_en, driver_data}, {1'b1, r_cmd});
      end
      driver_read = 1'b1;
      tick();
      driver_read = 1'b0;
      check_output("rnd_consumed", master_en, 0);
      model_last = exp_win;
      if (r_cmd[0]) begin
        check_output("rnd_wr_idle", busy, 0);
      end else begin
        r_k     = $urandom_range(1, TMO + 3);
        r_match = ($urandom_range(0, 3) != 0);
        r_data  = 8'($urandom);
        r_addr  = r_cmd[3 +: 8];
        r_at     = (r_k <= TMO) ? r_k : TMO;
        exp_data = (r_k <= TMO) ? r_data : 8'h00;
        exp_err  = (r_k <= TMO) ? !r_match : 1'b1;
        early = 1'b0;
        for (int j = 1; j <= r_at; j++) begin
          if (j == r_k) begin
            spi_rd_valid = 1'b1;
            spi_slv_addr = r_match ? r_addr : (r_addr ^ 8'h01);
            spi_slv_data = r_data;
          end else begin
            driver_read = 1'($urandom_range(0, 1));
          end
          tick();
          spi_rd_valid = 1'b0; driver_read = 1'b0;
          if (j < r_at) early |= (rsp_valid != 0);
        end
        check_output("rnd_no_early_rsp", early, 0);
        check_output("rnd_rsp", {rsp_valid, rsp_data, rsp_err},
                     {4'(1) << exp_win, exp_data, exp_err});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
